// File: rtl/aes_blok_alici.sv
`default_nettype none
// ============================================================================
// Module   : aes_blok_alici
// Purpose  : Input-side block receiver for the AES engine. Plaintext blocks
//            are buffered in a FIFO; nothing reaches the cipher core until the
//            FIFO has filled once (start-when-full). After that, blocks are
//            streamed to the core over valid/ready, and hazir is raised.
// Ports    : clk              - clock, all logic on posedge
//            rst              - synchronous active-high reset
//            blok / g_gecerli - incoming block and its valid
//            giris_hazir      - FIFO not full
//            hazir            - initial fill done (streaming state)
//            cekirdek_blok    - FIFO head (show-ahead) to the core
//            cekirdek_gecerli - cekirdek_blok valid
//            cekirdek_hazir   - core accepts a block this cycle
//            doluluk          - occupancy, 0..DERINLIK
//            dusen_sayisi     - saturating count of blocks dropped when full
// Options  : AES_BLOK_ALICI_YENIDEN_DOLDUR_EN - when defined, draining the
//            FIFO to empty returns to the filling state (refill before
//            streaming again); otherwise streaming is terminal until reset.
// Revision : 1.0 - initial release
// ============================================================================
module aes_blok_alici #(
  parameter int DERINLIK = 8,
  parameter int VERI_W   = 128,
  parameter int SAYAC_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [VERI_W-1:0]           blok,
  input  logic                        g_gecerli,
  output logic                        giris_hazir,
  output logic                        hazir,
  output logic [VERI_W-1:0]           cekirdek_blok,
  output logic                        cekirdek_gecerli,
  input  logic                        cekirdek_hazir,
  output logic [$clog2(DERINLIK):0]   doluluk,
  output logic [SAYAC_W-1:0]          dusen_sayisi
);

  localparam int c_AW = $clog2(DERINLIK);

  localparam logic [c_AW:0]      c_DOLU      = (c_AW+1)'(DERINLIK);
  localparam logic [c_AW:0]      c_DOLU_EKSI = (c_AW+1)'(DERINLIK - 1);
  localparam logic [c_AW:0]      c_SAY_BIR   = (c_AW+1)'(1);
  localparam logic [c_AW-1:0]    c_PTR_BIR   = c_AW'(1);
  localparam logic [SAYAC_W-1:0] c_DUS_BIR   = SAYAC_W'(1);
  localparam logic [SAYAC_W-1:0] c_DUS_MAX   = {SAYAC_W{1'b1}};

  // FSM encoding
  localparam logic [0:0] c_DOLDUR = 1'b0;
  localparam logic [0:0] c_AKIS   = 1'b1;

  logic [VERI_W-1:0] r_mem [DERINLIK];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_doluluk;
  logic [SAYAC_W-1:0] r_dusen;
  logic [0:0]        r_durum;

  logic w_full;
  logic w_empty;
  logic w_gecerli;
  logic w_push;
  logic w_pop;

  assign w_full    = (r_doluluk == c_DOLU);
  assign w_empty   = (r_doluluk == '0);
  assign w_gecerli = (r_durum == c_AKIS) && !w_empty;
  // No ready-through: a push arriving while full is dropped even if a pop
  // frees a slot on the same edge.
  assign w_push    = g_gecerli && !w_full;
  assign w_pop     = w_gecerli && cekirdek_hazir;

  assign giris_hazir      = !w_full;
  assign hazir            = (r_durum == c_AKIS);
  assign cekirdek_gecerli = w_gecerli;
  // Head is masked while not valid so unwritten storage never shows up as X.
  assign cekirdek_blok    = w_gecerli ? r_mem[r_rd_ptr] : '0;
  assign doluluk          = r_doluluk;
  assign dusen_sayisi     = r_dusen;

  // Storage is not reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= blok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_doluluk <= '0;
      r_dusen   <= '0;
      r_durum   <= c_DOLDUR;
    end else begin
      // Pointers wrap naturally because DERINLIK is a power of two.
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_BIR;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_BIR;

      case ({w_push, w_pop})
        2'b10:   r_doluluk <= r_doluluk + c_SAY_BIR;
        2'b01:   r_doluluk <= r_doluluk - c_SAY_BIR;
        default: r_doluluk <= r_doluluk;
      endcase

      if (g_gecerli && w_full && (r_dusen != c_DUS_MAX)) begin
        r_dusen <= r_dusen + c_DUS_BIR;
      end

      case (r_durum)
        c_DOLDUR: begin
          // No pops while filling, so the filling push is the one that
          // arrives with exactly one free slot.
          if (w_push && (r_doluluk == c_DOLU_EKSI)) r_durum <= c_AKIS;
        end
        c_AKIS: begin
`ifdef AES_BLOK_ALICI_YENIDEN_DOLDUR_EN
          if (w_pop && !w_push && (r_doluluk == c_SAY_BIR)) r_durum <= c_DOLDUR;
`else
          r_durum <= c_AKIS;
`endif
        end
        default: r_durum <= c_DOLDUR;
      endcase
    end
  end

endmodule
`default_nettype wire
